// File: rtl/psram_arb_pkg.sv
// Shared encodings for the PSRAM command-port arbiter and the EF_PSRAM_CTRL_V2 interface.
package psram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam logic       PSRAM_RD        = 1'b1;
    localparam logic       PSRAM_WR        = 1'b0;
    localparam logic [2:0] SIZE_B          = 3'b000;
    localparam logic [2:0] SIZE_H          = 3'b001;
    localparam logic [2:0] SIZE_W          = 3'b010;
    localparam logic [7:0] PSRAM_CMD_QREAD = 8'hEB;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping mod N_REQ.
module rr_priority_pick #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx
);

    int unsigned pos;

    // Scan farthest-first so the closest valid index to ptr is the last (winning) assignment.
    always_comb begin
        grant = '0;
        idx   = '0;
        pos   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = (32'(ptr) + N_REQ - 1 - k) % N_REQ;
            if (valid[pos]) begin
                grant      = '0;
                grant[pos] = 1'b1;
                idx        = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/psram_rr_arbiter.sv
// Round-robin arbiter sharing one PSRAM controller command port among N_REQ layer engines,
// one transaction at a time, with a WAIT-state watchdog.
module psram_rr_arbiter
    import psram_arb_pkg::*;
#(
    parameter int unsigned N_REQ          = 3,
    parameter int unsigned ADDR_WIDTH     = 24,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_rd_wr,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [N_REQ*3-1:0]          req_size,
    output logic [N_REQ-1:0]            req_ack,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic                        rsp_err,
    output logic                        busy,
    output logic [ADDR_WIDTH-1:0]       psram_addr,
    output logic [DATA_WIDTH-1:0]       psram_data_i,
    output logic [2:0]                  psram_size,
    output logic                        psram_rd_wr,
    output logic                        psram_start,
    input  logic [DATA_WIDTH-1:0]       psram_data_o,
    input  logic                        psram_done
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned WD_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    arb_state_t       state, state_nxt;
    logic [N_REQ-1:0] pick_oh, g_oh;
    logic [IDX_W-1:0] pick_idx, g_idx, rr_ptr;
    logic [WD_W-1:0]  wd_cnt;
    logic             timeout_hit;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_oh),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        req_ack     = '0;
        rsp_valid   = '0;
        psram_start = 1'b0;
        busy        = (state != ST_IDLE);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST);
        case (state)
            ST_IDLE:  if (|req_valid) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                req_ack     = g_oh;
                psram_start = 1'b1;
                state_nxt   = ST_WAIT;
            end
            ST_WAIT:  if (psram_done || timeout_hit) state_nxt = ST_RESP;
            ST_RESP: begin
                rsp_valid = g_oh;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_oh         <= '0;
            g_idx        <= '0;
            rr_ptr       <= '0;
            wd_cnt       <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            psram_addr   <= '0;
            psram_data_i <= '0;
            psram_size   <= SIZE_W;
            psram_rd_wr  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wd_cnt <= '0;
                    if (|req_valid) begin
                        g_oh         <= pick_oh;
                        g_idx        <= pick_idx;
                        psram_addr   <= req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        psram_data_i <= req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                        psram_size   <= req_size[pick_idx*3 +: 3];
                        psram_rd_wr  <= req_rd_wr[pick_idx];
                    end
                end
                // Done takes priority over a watchdog expiry in the same cycle.
                ST_WAIT: begin
                    if (psram_done) begin
                        rsp_rdata <= (psram_rd_wr == PSRAM_RD) ? psram_data_o : '0;
                        rsp_err   <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_RESP: rr_ptr <= (g_idx == IDX_W'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
                default: ;
            endcase
        end
    end

endmodule
